// File: rtl/jk_seq_ctrl.sv
// Command-driven j/k sequencer for a bank of WIDTH JK flops.
// Define JK_SEQ_CHECK_EN to add the CHECK state, readback compare, err and q_snap.
module jk_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] q_snap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] eff_count;
    logic [WIDTH-1:0] j_n, k_n;
    logic             done_n;
    logic             accept;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign eff_count = (cmd_count == '0) ? CNT_W'(1) : cmd_count;

    // The j/k registers themselves hold the latched op/mask for the whole apply window.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        j_n     = j;
        k_n     = k;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                j_n = '0;
                k_n = '0;
                if (accept) begin
                    state_n = APPLY;
                    cnt_n   = eff_count;
                    case (cmd_op)
                        2'b01: j_n = cmd_mask;
                        2'b10: k_n = cmd_mask;
                        2'b11: begin
                            j_n = cmd_mask;
                            k_n = cmd_mask;
                        end
                        default: ;
                    endcase
                end
            end
            APPLY: begin
                if (cnt == CNT_W'(1)) begin
                    j_n = '0;
                    k_n = '0;
`ifdef JK_SEQ_CHECK_EN
                    state_n = CHECK;
`else
                    state_n = IDLE;
                    done_n  = 1'b1;
`endif
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
`ifdef JK_SEQ_CHECK_EN
            CHECK: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
`endif
            default: begin
                state_n = IDLE;
                j_n     = '0;
                k_n     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            j     <= '0;
            k     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            j     <= j_n;
            k     <= k_n;
            done  <= done_n;
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_q, exp_n;
    logic [WIDTH-1:0] snap_q, snap_n;
    logic             err_q, err_n;

    // Toggle parity uses the effective count, so a zero count flips once.
    always_comb begin
        exp_n  = exp_q;
        snap_n = snap_q;
        err_n  = 1'b0;
        if (accept) begin
            case (cmd_op)
                2'b01:   exp_n = q | cmd_mask;
                2'b10:   exp_n = q & ~cmd_mask;
                2'b11:   exp_n = q ^ (eff_count[0] ? cmd_mask : '0);
                default: exp_n = q;
            endcase
        end
        if (state == CHECK) begin
            err_n  = (q != exp_q);
            snap_n = q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q  <= '0;
            snap_q <= '0;
            err_q  <= 1'b0;
        end else begin
            exp_q  <= exp_n;
            snap_q <= snap_n;
            err_q  <= err_n;
        end
    end

    assign err    = err_q;
    assign q_snap = snap_q;
`else
    logic unused_q;

    assign unused_q = ^q;
    assign err      = 1'b0;
    assign q_snap   = '0;
`endif

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed bench for jk_seq_ctrl with a behavioural JK bank on the j/k/q loop.
module tb_jk_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_mask;
    logic [7:0] cmd_count;
    logic [3:0] j, k, q, q_snap;
    logic       busy, done, err;

    logic [3:0] q_bank;
    logic       load_en;
    logic [3:0] load_val;
    logic       stuck;

    int checks = 0;
    int errors = 0;

    jk_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_count (cmd_count),
        .j         (j),
        .k         (k),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .q_snap    (q_snap)
    );

    always #5 clk = ~clk;

    // JK bank: q+ = j&~q | ~k&q, with a direct load for scenario setup.
    always @(posedge clk) begin
        if (load_en) q_bank <= load_val;
        else         q_bank <= (j & ~q_bank) | (~k & q_bank);
    end

    assign q = stuck ? 4'b0000 : q_bank;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Issue a command at the current negedge and follow it to its done cycle.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] mask,
                           input logic [7:0] count, input int n,
                           input logic [3:0] jv, input logic [3:0] kv, input logic [3:0] qv,
                           input logic ev, input logic [3:0] sv);
        logic       e_err;
        logic [3:0] e_snap;
`ifdef JK_SEQ_CHECK_EN
        e_err  = ev;
        e_snap = sv;
`else
        e_err  = 1'b0;
        e_snap = 4'b0000;
`endif
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_count = count;
        chk({name, ".ready"}, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= n; c++) begin
            chk({name, ".j"}, 32'(j), 32'(jv));
            chk({name, ".k"}, 32'(k), 32'(kv));
            chk({name, ".busy"}, 32'(busy), 32'd1);
            chk({name, ".done_early"}, 32'(done), 32'd0);
            if (c < n) step();
        end
        step();
`ifdef JK_SEQ_CHECK_EN
        chk({name, ".chk_j"}, 32'(j), 32'd0);
        chk({name, ".chk_k"}, 32'(k), 32'd0);
        chk({name, ".chk_busy"}, 32'(busy), 32'd1);
        chk({name, ".chk_done"}, 32'(done), 32'd0);
        step();
`endif
        chk({name, ".done"}, 32'(done), 32'd1);
        chk({name, ".err"}, 32'(err), 32'(e_err));
        chk({name, ".q_snap"}, 32'(q_snap), 32'(e_snap));
        chk({name, ".ready_at_done"}, 32'(cmd_ready), 32'd1);
        chk({name, ".busy_at_done"}, 32'(busy), 32'd0);
        chk({name, ".j_idle"}, 32'(j), 32'd0);
        chk({name, ".q_final"}, 32'(q), 32'(qv));
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_mask  = 4'b0000;
        cmd_count = 8'd0;
        stuck     = 1'b0;
        load_en   = 1'b1;
        load_val  = 4'b0000;
        step();
        step();
        chk("rst.j", 32'(j), 32'd0);
        chk("rst.k", 32'(k), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready", 32'(cmd_ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.q_snap", 32'(q_snap), 32'd0);
        rst     = 1'b0;
        load_en = 1'b0;
        step();

        run_cmd("set", 2'b01, 4'b0101, 8'd1, 1, 4'b0101, 4'b0000, 4'b0101, 1'b0, 4'b0101);
        step();
        chk("set.done_pulse", 32'(done), 32'd0);
        chk("set.err_clear", 32'(err), 32'd0);

        run_cmd("tog3", 2'b11, 4'b1111, 8'd3, 3, 4'b1111, 4'b1111, 4'b1010, 1'b0, 4'b1010);
        step();

        stuck = 1'b1;
        run_cmd("stuck", 2'b01, 4'b1000, 8'd2, 2, 4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        stuck = 1'b0;
        step();
        chk("stuck.done_pulse", 32'(done), 32'd0);
`ifdef JK_SEQ_CHECK_EN
        chk("stuck.snap_hold", 32'(q_snap), 32'd0);
`endif
        load_en  = 1'b1;
        load_val = 4'b1111;
        step();
        load_en = 1'b0;

        run_cmd("cnt0", 2'b10, 4'b0011, 8'd0, 1, 4'b0000, 4'b0011, 4'b1100, 1'b0, 4'b1100);
        run_cmd("b2b_hold", 2'b00, 4'b1111, 8'd4, 4, 4'b0000, 4'b0000, 4'b1100, 1'b0, 4'b1100);
        step();
        chk("b2b.done_pulse", 32'(done), 32'd0);

        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_mask  = 4'b1111;
        cmd_count = 8'd5;
        step();
        cmd_valid = 1'b0;
        chk("abort.j1", 32'(j), 32'hF);
        chk("abort.k1", 32'(k), 32'hF);
        step();
        chk("abort.busy2", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.j", 32'(j), 32'd0);
        chk("abort.k", 32'(k), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.ready", 32'(cmd_ready), 32'd1);
        chk("abort.done", 32'(done), 32'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("abort.no_done", 32'(done), 32'd0);
        end

        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_mask  = 4'b1111;
        cmd_count = 8'd1;
        step();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        chk("rstwin.busy", 32'(busy), 32'd0);
        chk("rstwin.j", 32'(j), 32'd0);
        step();
        chk("rstwin.busy2", 32'(busy), 32'd0);
        chk("rstwin.done", 32'(done), 32'd0);

        load_en  = 1'b1;
        load_val = 4'b1001;
        step();
        load_en = 1'b0;
        run_cmd("tog2", 2'b11, 4'b0110, 8'd2, 2, 4'b0110, 4'b0110, 4'b1001, 1'b0, 4'b1001);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
